slow_tick_timer: RTL and testbench
==================================

# slow_tick_timer

Fast-domain consumer of the divided slow clock. Synchronises the free-running `slow_clk` into the `clk` domain, converts each rising edge into a single-cycle `tick` enable, and runs a loadable down-counter of ticks with start/abort/expire handshaking. Game logic uses it for mole-visible and round-length timeouts, so no logic is ever clocked directly by `slow_clk`.

## Interface
Parameters:
- `SYNC_STAGES`, 2, flops in the `slow_clk` synchroniser (legal ≥ 2).
- `CNT_W`, 8, width of the tick count and `load_ticks`.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `slow_clk`  in  1  divided clock, asynchronous to `clk`, treated as data.
- `start`  in  1  level-sampled; load `load_ticks` and begin counting.
- `abort`  in  1  cancel a running count without an expire.
- `load_ticks`  in  CNT_W  number of slow-clock rising edges to wait.
- `tick`  out  1  one-cycle pulse per `slow_clk` rising edge.
- `busy`  out  1  high while in RUN.
- `remaining`  out  CNT_W  ticks left in the current count.
- `expired`  out  1  one-cycle pulse when the count reaches zero.

## Operation
- Reset (`reset`=0, asynchronous): sync chain and edge register are 0, state IDLE. Outputs: `tick`=0, `busy`=0, `remaining`=0, `expired`=0.
- Synchroniser: `slow_clk` → SYNC_STAGES flops → `prev` flop. `tick` is registered: `tick <= sync_last & ~prev`. A rising edge gives exactly one `tick`. A falling edge gives none.
- `slow_clk` held high through reset: one `tick` is produced after reset release. This is intended.
- States: IDLE, RUN, DONE.
- IDLE:
  - `start` with `load_ticks`≠0 → RUN, `remaining`←`load_ticks`.
  - `start` with `load_ticks`=0 → DONE, `remaining`←0.
  - Otherwise stay in IDLE; `remaining` holds its value.
- RUN:
  - Priority: `abort` > `start` > `tick`.
  - `abort` → IDLE, `remaining`←0, no `expired`.
  - `start` restarts: reload `load_ticks`, or go to DONE if it is 0. A coincident tick is dropped.
  - `tick` with `remaining`>1 → decrement.
  - `tick` with `remaining`=1 → `remaining`←0, go to DONE.
- DONE: `expired`=1 for exactly one cycle, then IDLE unconditionally. `start` and `abort` are ignored in DONE.
- `busy` = (state==RUN). `expired` = (state==DONE). Both are decoded from the state register, so they are glitch-free.
- Arithmetic: the decrement never wraps; `remaining` stays in [0, 2^CNT_W−1].

## Timing
- Edge latency: edge E is the first `clk` edge that samples `slow_clk` high. `tick` is high in the cycle after edge E+SYNC_STAGES, i.e. 3 cycles later for the default.
- Minimum `slow_clk` high and low time is SYNC_STAGES+1 `clk` cycles. Shorter pulses may be lost; this is not checked.
- Start latency: `start` sampled at edge N → `busy`=1 and `remaining`=`load_ticks` after edge N.
- Decrement: a `tick` high in cycle t updates `remaining` at the edge ending cycle t.
- Final tick: `remaining` becomes 0 and `expired`=1 in the same following cycle. `busy` falls at that same edge.
- Zero load: `expired` is high in the cycle after the `start` edge.
- Back-to-back: `start` can be accepted in the cycle after `expired`, because the block is already in IDLE.
- Reset mid-count: state returns to IDLE immediately and no `expired` is produced.

## Structure
- Package `slow_tick_pkg`:
  - state enum {IDLE=2'd0, RUN=2'd1, DONE=2'd2}.
  - default constants `SYNC_STAGES_DEF=2`, `CNT_W_DEF=8`.
- Sub-module `slow_clk_sync`: the synchroniser, `prev` flop and registered `tick`. Parameterised by SYNC_STAGES, reset with the same active-low asynchronous reset.
- Top level: FSM plus `remaining` counter only.

## Test plan
- Edge detect: `slow_clk` period 20 `clk` (10 high / 10 low), 5 periods → exactly 5 `tick` pulses. Each pulse is 1 cycle wide and 3 cycles after the sampled rise.
- Full count: `load_ticks`=3, `start` 1 cycle → `busy` for 3 ticks, `remaining` 3→2→1→0. `expired` is 1 cycle, coincident with `remaining`=0.
- Zero load: `load_ticks`=0, `start` → `expired` the next cycle, `busy` never high.
- Abort: `load_ticks`=5, `abort` after 2 ticks → IDLE, `remaining`=0, no `expired`. Also assert `abort` and `start` together in RUN → abort wins.
- Restart collision: in RUN with `remaining`=2, `start` with `load_ticks`=4 in the same cycle as `tick` → `remaining`=4, tick not counted.
- Async reset: `reset` low mid-count with `remaining`=7 → all outputs 0 without a clock edge. With `slow_clk` held high through the reset, exactly one `tick` follows release.

Source files
------------

// File: rtl/slow_tick_pkg.sv
// slow_tick_pkg
// Shared definitions for the slow-clock tick timer: FSM state encoding and
// default parameter values used by slow_tick_timer and slow_clk_sync.
package slow_tick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/slow_clk_sync.sv
// slow_clk_sync
// Brings the free-running divided clock into the clk domain as plain data and
// turns each rising edge into a registered one-cycle tick.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   slow_clk in   divided clock, asynchronous to clk
//   tick     out  one-cycle pulse per slow_clk rising edge
module slow_clk_sync
  import slow_tick_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic slow_clk,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // prev_q clears with the chain, so a slow_clk held high through reset
  // still yields one tick after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
      tick   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/slow_tick_timer.sv
// slow_tick_timer
// Loadable down-counter of slow_clk rising edges with start/abort/expire
// handshaking. Nothing here is clocked by slow_clk; it only enters as data.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   slow_clk   in   divided clock, treated as data
//   start      in   load load_ticks and begin counting
//   abort      in   cancel a running count, no expire
//   load_ticks in   number of slow_clk rising edges to wait
//   tick       out  one-cycle pulse per slow_clk rising edge
//   busy       out  high while counting
//   remaining  out  ticks left in the current count
//   expired    out  one-cycle pulse when the count reaches zero
//
// State | Meaning
// IDLE  | waiting for start; remaining holds its last value
// RUN   | counting ticks down; abort > start > tick
// DONE  | expired pulse for one cycle, then IDLE regardless of inputs
module slow_tick_timer
  import slow_tick_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] load_ticks,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             expired
);

  state_t state;

  slow_clk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .slow_clk (slow_clk),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= load_ticks;
            state     <= (load_ticks == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            remaining <= '0;
            state     <= IDLE;
          end else if (start) begin
            // restart wins over a coincident tick, which is dropped
            remaining <= load_ticks;
            state     <= (load_ticks == '0) ? DONE : RUN;
          end else if (tick) begin
            // remaining is never 0 in RUN, so this cannot wrap
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign expired = (state == DONE);

endmodule

// File: tb/tb_slow_tick_timer.sv
module tb_slow_tick_timer;

  localparam int SS = 2;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       slow_clk   = 1'b0;
  logic       start      = 1'b0;
  logic       abort      = 1'b0;
  logic [7:0] load_ticks = 8'd0;
  logic       tick;
  logic       busy;
  logic       expired;
  logic [7:0] remaining;

  slow_tick_timer #(.SYNC_STAGES(SS), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .slow_clk   (slow_clk),
    .start      (start),
    .abort      (abort),
    .load_ticks (load_ticks),
    .tick       (tick),
    .busy       (busy),
    .remaining  (remaining),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tick;
    bit busy;
    int rem;
    bit expd;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_fail    = 0;
  int   tick_seen = 0;
  int   exp_seen  = 0;

  // reference model: slow_clk samples since reset, plus an abstract timer
  bit   samp[$];
  bit   m_run, m_done, m_tick;
  int   m_rem;

  bit   slow_en   = 1'b0;
  int   slow_half = 0;
  int   slow_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  function automatic void model_clear();
    samp.delete();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_tick = 1'b0;
    m_rem  = 0;
  endfunction

  function automatic void model_load();
    if (load_ticks == 8'd0) begin
      m_run  = 1'b0;
      m_done = 1'b1;
      m_rem  = 0;
    end else begin
      m_run  = 1'b1;
      m_rem  = int'(load_ticks);
    end
  endfunction

  // called at each active edge, with the inputs that were held over the cycle
  function automatic void model_edge();
    bit t_in;
    int n;
    rec_t r;
    t_in = m_tick;
    samp.push_back(slow_clk);
    n = samp.size() - 1 - SS;
    // a rise sampled at edge n shows as tick right after edge n+SS
    m_tick = (n >= 0) && samp[n] && ((n == 0) || !samp[n-1]);
    if (m_done) m_done = 1'b0;
    else if (!m_run) begin
      if (start) model_load();
    end else if (abort) begin
      m_run = 1'b0;
      m_rem = 0;
    end else if (start) model_load();
    else if (t_in) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
    r.tick = m_tick;
    r.busy = m_run;
    r.rem  = m_rem;
    r.expd = m_done;
    exp_q.push_back(r);
  endfunction

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic st, input logic ab, input logic [7:0] ld);
    start      = st;
    abort      = ab;
    load_ticks = ld;
    if (slow_en) begin
      if (slow_left <= 1) begin
        slow_clk  = ~slow_clk;
        slow_left = (slow_half != 0) ? slow_half : int'($urandom_range(3, 8));
      end else slow_left--;
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic [7:0] ld);
    clk_edge();
    drive(st, ab, ld);
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int i;
    i = 0;
    while ((m_run || m_done) && i < budget) begin
      step(1'b0, 1'b0, 8'd0);
      i++;
    end
    check({name, "_timeout"}, 32'(m_run || m_done), 32'd0);
  endtask

  // monitor: pops one expected record per cycle once the model is running
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (tick)    tick_seen++;
      if (expired) exp_seen++;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("tick",      32'(tick),      32'(r.tick));
        check("busy",      32'(busy),      32'(r.busy));
        check("remaining", 32'(remaining), 32'(r.rem));
        check("expired",   32'(expired),   32'(r.expd));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e0;
    bit  found;
    int  i;

    // asynchronous reset with no clock edge in between
    #2 reset = 1'b0;
    #1;
    check("rst_tick",      32'(tick),      32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_expired",   32'(expired),   32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    model_clear();

    // edge detect: 5 periods of 10 high / 10 low
    tick_seen = 0;
    slow_en   = 1'b1;
    slow_half = 10;
    slow_left = 10;
    repeat (100) step(1'b0, 1'b0, 8'd0);
    slow_en = 1'b0;
    repeat (6) step(1'b0, 1'b0, 8'd0);
    check("edge_tick_count", 32'(tick_seen), 32'd5);

    // full count of 3
    slow_en = 1'b1;
    e0 = exp_seen;
    step(1'b1, 1'b0, 8'd3);
    step(1'b0, 1'b0, 8'd0);
    run_until_idle("full_count", 200);
    step(1'b0, 1'b0, 8'd0);
    check("full_count_expired", 32'(exp_seen - e0), 32'd1);

    // zero load
    e0 = exp_seen;
    step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    check("zero_load_expired", 32'(exp_seen - e0), 32'd1);

    // abort after 2 ticks
    e0 = exp_seen;
    step(1'b1, 1'b0, 8'd5);
    step(1'b0, 1'b0, 8'd0);
    i = 0;
    while (m_run && m_rem > 3 && i < 200) begin
      step(1'b0, 1'b0, 8'd0);
      i++;
    end
    check("abort_reached", 32'(m_rem), 32'd3);
    step(1'b0, 1'b1, 8'd0);
    repeat (4) step(1'b0, 1'b0, 8'd0);
    check("abort_no_expired", 32'(exp_seen - e0), 32'd0);
    check("abort_remaining",  32'(remaining),     32'd0);

    // abort and start together in RUN
    step(1'b1, 1'b0, 8'd5);
    step(1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd9);
    repeat (3) step(1'b0, 1'b0, 8'd0);
    check("abort_wins_busy", 32'(busy), 32'd0);

    // restart colliding with a tick at remaining=2
    step(1'b1, 1'b0, 8'd3);
    found = 1'b0;
    i = 0;
    while (!found && i < 200) begin
      clk_edge();
      if (m_run && m_rem == 2 && m_tick) begin
        drive(1'b1, 1'b0, 8'd4);
        found = 1'b1;
      end else drive(1'b0, 1'b0, 8'd0);
      i++;
    end
    check("collision_found", 32'(found), 32'd1);
    step(1'b0, 1'b0, 8'd0);
    check("collision_rem", 32'(remaining), 32'd4);
    run_until_idle("collision", 300);

    // randomized traffic with irregular slow_clk
    slow_half = 0;
    repeat (600)
      step(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 19) == 0),
           8'($urandom_range(0, 6)));
    run_until_idle("random", 500);

    // reset mid-count with remaining=7, slow_clk held high through reset
    slow_en  = 1'b0;
    slow_clk = 1'b0;
    repeat (6) step(1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd7);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    check("pre_reset_rem", 32'(remaining), 32'd7);
    e0 = exp_seen;
    @(posedge clk);
    #3 reset = 1'b0;
    slow_clk = 1'b1;
    start    = 1'b0;
    #1;
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_remaining", 32'(remaining), 32'd0);
    check("mid_rst_expired",   32'(expired),   32'd0);
    check("mid_rst_tick",      32'(tick),      32'd0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    model_clear();
    tick_seen = 0;
    repeat (10) step(1'b0, 1'b0, 8'd0);
    check("post_reset_ticks",   32'(tick_seen),     32'd1);
    check("reset_no_expired",   32'(exp_seen - e0), 32'd0);

    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
